// File: rtl/itr_pkg.sv
// itr_pkg: shared FSM encoding, limits and vector address helper for itr_ctrl
package itr_pkg;
  localparam int NITR_MAX = 16;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ = 1'b1;
  function automatic int unsigned vec_addr(input int unsigned idx, input int unsigned base,
                                           input int unsigned step);
    return base + idx * step;
  endfunction
endpackage

// File: rtl/itr_prio_enc.sv
// prio_enc: index of the lowest set request bit plus a valid flag
module prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         vld
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = req[i] ? W'(i) : idx;
    vld = |req;
  end
endmodule

// File: rtl/itr_ctrl.sv
// itr_ctrl: vectored, prioritised, maskable interrupt controller with optional nesting
module itr_ctrl
  import itr_pkg::*;
#(
  parameter int NITR    = 4,
  parameter int MINSTW  = 9,
  parameter int ITRBASE = 1,
  parameter int VSTEP   = 2,
  parameter int EDGE    = 1,
  parameter int NEST    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NITR-1:0]   src,
  input  logic              mask_wr,
  input  logic [NITR-1:0]   mask_in,
  output logic [NITR-1:0]   mask_out,
  output logic              itr,
  output logic [MINSTW-1:0] itr_addr,
  input  logic              itr_ack,
  input  logic              itr_ret,
  output logic [NITR-1:0]   pend,
  output logic [NITR-1:0]   isv
);
  localparam int IW = (NITR > 1) ? $clog2(NITR) : 1;
  if (NITR < 1 || NITR > NITR_MAX) begin : g_bad_nitr
    $error("itr_ctrl: NITR out of range");
  end
  if (ITRBASE + (NITR - 1) * VSTEP >= 2 ** MINSTW) begin : g_bad_addr
    $error("itr_ctrl: vector table does not fit in MINSTW bits");
  end
  logic [0:0]      st;
  logic [IW-1:0]   w, hi, widx;
  logic            w_vld, hi_vld, elig, ack;
  logic [NITR-1:0] src_d, ack_bit, ret_bit;
  prio_enc #(.N(NITR), .W(IW)) u_win (.req(pend & mask_out), .idx(w), .vld(w_vld));
  prio_enc #(.N(NITR), .W(IW)) u_isv (.req(isv), .idx(hi), .vld(hi_vld));
  // a nested request must strictly outrank every source already in service
  always_comb begin
    elig = w_vld && (!hi_vld || (NEST != 0 && w < hi));
    ack = st == S_REQ && itr_ack;
    ack_bit = ack ? NITR'(1) << widx : '0;
    ret_bit = (itr_ret && hi_vld) ? NITR'(1) << hi : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_IDLE;
      src_d <= '0;
      mask_out <= '0;
      pend <= '0;
      isv <= '0;
      widx <= '0;
      itr <= 1'b0;
      itr_addr <= '0;
    end else begin
      src_d <= src;
      if (mask_wr) mask_out <= mask_in;
      pend <= (EDGE != 0) ? (pend & ~ack_bit) | (src & ~src_d) : src & ~isv;
      isv <= (isv & ~ret_bit) | ack_bit;
      if (st == S_IDLE && elig) begin
        st <= S_REQ;
        widx <= w;
        itr <= 1'b1;
        itr_addr <= MINSTW'(vec_addr(32'(w), ITRBASE, VSTEP));
      end else if (ack) begin
        st <= S_IDLE;
        itr <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_itr_ctrl.sv
// tb_itr_ctrl: directed and randomised checks of three itr_ctrl variants against a behavioural model
module tb_itr_ctrl;
  logic clk = 1'b0, rst = 1'b0, mask_wr = 1'b0, itr_ack = 1'b0, itr_ret = 1'b0;
  logic [3:0] src = '0, mask_in = '0;
  logic [2:0] o_itr;
  logic [2:0][8:0] o_addr;
  logic [2:0][3:0] o_mask, o_pend, o_isv;
  int checks = 0, passes = 0;
  logic [3:0] m_pend[3], m_isv[3];
  logic [3:0] m_mask, m_prev;
  bit m_req[3];
  int m_idx[3];
  always #5 clk = ~clk;
  // variant 0: edge/no-nest, 1: edge/nest, 2: level/no-nest
  for (genvar g = 0; g < 3; g++) begin : g_dut
    itr_ctrl #(.EDGE(g != 2 ? 1 : 0), .NEST(g == 1 ? 1 : 0)) u (
      .clk(clk), .rst(rst), .src(src), .mask_wr(mask_wr), .mask_in(mask_in),
      .mask_out(o_mask[g]), .itr(o_itr[g]), .itr_addr(o_addr[g]), .itr_ack(itr_ack),
      .itr_ret(itr_ret), .pend(o_pend[g]), .isv(o_isv[g]));
  end
  task automatic model_step();
    int w, lo;
    bit acked;
    logic [3:0] np, ni;
    for (int v = 0; v < 3; v++) begin
      w = -1;
      lo = -1;
      for (int i = 3; i >= 0; i--) begin
        if (m_pend[v][i] && m_mask[i]) w = i;
        if (m_isv[v][i]) lo = i;
      end
      acked = m_req[v] && itr_ack;
      ni = m_isv[v];
      if (itr_ret && lo >= 0) ni[lo] = 1'b0;
      if (acked) ni[m_idx[v]] = 1'b1;
      if (v == 2) np = src & ~m_isv[v];
      else begin
        np = m_pend[v];
        if (acked) np[m_idx[v]] = 1'b0;
        for (int i = 0; i < 4; i++) if (src[i] && !m_prev[i]) np[i] = 1'b1;
      end
      if (!m_req[v] && w >= 0 && (lo < 0 || (v == 1 && w < lo))) begin
        m_req[v] = 1'b1;
        m_idx[v] = w;
      end else if (acked) m_req[v] = 1'b0;
      m_pend[v] = rst ? 4'b0 : np;
      m_isv[v] = rst ? 4'b0 : ni;
      if (rst) m_req[v] = 1'b0;
    end
    m_mask = rst ? 4'b0 : (mask_wr ? mask_in : m_mask);
    m_prev = rst ? 4'b0 : src;
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      model_step();
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    {src, mask_wr, itr_ack, itr_ret} = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask
  task automatic set_mask(input logic [3:0] m);
    mask_wr = 1'b1;
    mask_in = m;
    cyc();
    mask_wr = 1'b0;
  endtask
  task automatic pulse_ack();
    itr_ack = 1'b1;
    cyc();
    itr_ack = 1'b0;
  endtask
  task automatic pulse_ret();
    itr_ret = 1'b1;
    cyc();
    itr_ret = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    for (int v = 0; v < 3; v++) begin
      checks++;
      if ({o_itr[v], o_addr[v], o_mask[v], o_pend[v], o_isv[v]} !== 22'b0)
        $display("FAIL reset v%0d itr=%b addr=%0d mask=%b pend=%b isv=%b want all zero", v,
                 o_itr[v], o_addr[v], o_mask[v], o_pend[v], o_isv[v]);
      else passes++;
    end
  endtask
  task automatic test_basic();
    do_reset();
    set_mask(4'b1111);
    checks++;
    if (o_mask[0] !== 4'b1111) $display("FAIL basic_mask got %b want 1111", o_mask[0]); else passes++;
    src = 4'b0100;
    cyc();
    src = 4'b0;
    checks++;
    if (o_pend[0] !== 4'b0100 || o_itr[0] !== 1'b0)
      $display("FAIL basic_pend pend=%b itr=%b want 0100/0", o_pend[0], o_itr[0]);
    else passes++;
    cyc();
    checks++;
    if (o_itr[0] !== 1'b1 || o_addr[0] !== 9'd5)
      $display("FAIL basic_req itr=%b addr=%0d want 1/5", o_itr[0], o_addr[0]);
    else passes++;
    cyc();
    checks++;
    if (o_itr[0] !== 1'b1 || o_addr[0] !== 9'd5)
      $display("FAIL basic_hold itr=%b addr=%0d want 1/5", o_itr[0], o_addr[0]);
    else passes++;
    pulse_ack();
    checks++;
    if (o_itr[0] !== 1'b0 || o_isv[0] !== 4'b0100 || o_pend[0] !== 4'b0)
      $display("FAIL basic_ack itr=%b isv=%b pend=%b want 0/0100/0000", o_itr[0], o_isv[0], o_pend[0]);
    else passes++;
    cyc();
    checks++;
    if (o_itr[0] !== 1'b0) $display("FAIL basic_no_rereq itr=%b want 0", o_itr[0]); else passes++;
    pulse_ret();
    checks++;
    if (o_isv[0] !== 4'b0) $display("FAIL basic_ret isv=%b want 0000", o_isv[0]); else passes++;
  endtask
  task automatic test_priority();
    do_reset();
    set_mask(4'b1111);
    src = 4'b1010;
    cyc();
    src = 4'b0;
    cyc();
    checks++;
    if (o_itr[0] !== 1'b1 || o_addr[0] !== 9'd3)
      $display("FAIL prio_first itr=%b addr=%0d want 1/3", o_itr[0], o_addr[0]);
    else passes++;
    pulse_ack();
    checks++;
    if (o_isv[0] !== 4'b0010 || o_pend[0] !== 4'b1000)
      $display("FAIL prio_ack isv=%b pend=%b want 0010/1000", o_isv[0], o_pend[0]);
    else passes++;
    pulse_ret();
    checks++;
    if (o_itr[0] !== 1'b0 || o_isv[0] !== 4'b0)
      $display("FAIL prio_ret itr=%b isv=%b want 0/0000", o_itr[0], o_isv[0]);
    else passes++;
    cyc();
    checks++;
    if (o_itr[0] !== 1'b1 || o_addr[0] !== 9'd7)
      $display("FAIL prio_second itr=%b addr=%0d want 1/7", o_itr[0], o_addr[0]);
    else passes++;
  endtask
  task automatic test_mask();
    do_reset();
    set_mask(4'b1110);
    src = 4'b0001;
    cyc();
    src = 4'b0;
    cyc(2);
    checks++;
    if (o_itr[0] !== 1'b0 || o_pend[0] !== 4'b0001)
      $display("FAIL mask_block itr=%b pend=%b want 0/0001", o_itr[0], o_pend[0]);
    else passes++;
    set_mask(4'b1111);
    checks++;
    if (o_itr[0] !== 1'b0) $display("FAIL mask_wr_cycle itr=%b want 0", o_itr[0]); else passes++;
    cyc();
    checks++;
    if (o_itr[0] !== 1'b1 || o_addr[0] !== 9'd1)
      $display("FAIL mask_open itr=%b addr=%0d want 1/1", o_itr[0], o_addr[0]);
    else passes++;
  endtask
  task automatic test_nest();
    do_reset();
    set_mask(4'b1111);
    src = 4'b0100;
    cyc();
    src = 4'b0;
    cyc();
    pulse_ack();
    src = 4'b0001;
    cyc();
    src = 4'b0;
    cyc();
    checks++;
    if (o_itr[0] !== 1'b0) $display("FAIL nest_off_blocked itr=%b want 0", o_itr[0]); else passes++;
    checks++;
    if (o_itr[1] !== 1'b1 || o_addr[1] !== 9'd1)
      $display("FAIL nest_on_req itr=%b addr=%0d want 1/1", o_itr[1], o_addr[1]);
    else passes++;
    pulse_ack();
    checks++;
    if (o_isv[1] !== 4'b0101) $display("FAIL nest_on_isv isv=%b want 0101", o_isv[1]); else passes++;
    checks++;
    if (o_isv[0] !== 4'b0100 || o_pend[0] !== 4'b0001)
      $display("FAIL nest_stray_ack isv=%b pend=%b want 0100/0001", o_isv[0], o_pend[0]);
    else passes++;
    pulse_ret();
    checks++;
    if (o_isv[1] !== 4'b0100) $display("FAIL nest_on_ret isv=%b want 0100", o_isv[1]); else passes++;
    cyc();
    checks++;
    if (o_itr[0] !== 1'b1 || o_addr[0] !== 9'd1)
      $display("FAIL nest_off_after_ret itr=%b addr=%0d want 1/1", o_itr[0], o_addr[0]);
    else passes++;
  endtask
  task automatic test_boundary();
    do_reset();
    set_mask(4'b1111);
    src = 4'b0100;
    cyc();
    src = 4'b0;
    cyc();
    src = 4'b0100;
    pulse_ack();
    src = 4'b0;
    checks++;
    if (o_pend[0] !== 4'b0100 || o_isv[0] !== 4'b0100)
      $display("FAIL ack_vs_edge pend=%b isv=%b want 0100/0100", o_pend[0], o_isv[0]);
    else passes++;
    do_reset();
    set_mask(4'b1111);
    src = 4'b0100;
    cyc();
    src = 4'b0;
    cyc();
    pulse_ret();
    checks++;
    if (o_itr[0] !== 1'b1 || o_isv[0] !== 4'b0 || o_addr[0] !== 9'd5)
      $display("FAIL ret_empty itr=%b isv=%b addr=%0d want 1/0000/5", o_itr[0], o_isv[0], o_addr[0]);
    else passes++;
    src = 4'b1000;
    cyc();
    src = 4'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++;
    if (o_itr[0] !== 1'b0 || o_pend[0] !== 4'b0 || o_isv[0] !== 4'b0 || o_mask[0] !== 4'b0)
      $display("FAIL rst_in_req itr=%b pend=%b isv=%b mask=%b want all zero", o_itr[0], o_pend[0],
               o_isv[0], o_mask[0]);
    else passes++;
  endtask
  task automatic test_level();
    do_reset();
    set_mask(4'b1111);
    src = 4'b0010;
    cyc();
    checks++;
    if (o_itr[2] !== 1'b0) $display("FAIL lvl_latency itr=%b want 0", o_itr[2]); else passes++;
    cyc(2);
    checks++;
    if (o_itr[2] !== 1'b1 || o_addr[2] !== 9'd3)
      $display("FAIL lvl_req itr=%b addr=%0d want 1/3", o_itr[2], o_addr[2]);
    else passes++;
    pulse_ack();
    cyc(3);
    checks++;
    if (o_itr[2] !== 1'b0 || o_isv[2] !== 4'b0010)
      $display("FAIL lvl_no_rereq itr=%b isv=%b want 0/0010", o_itr[2], o_isv[2]);
    else passes++;
    pulse_ret();
    cyc();
    checks++;
    if (o_itr[2] !== 1'b0) $display("FAIL lvl_ret_latency itr=%b want 0", o_itr[2]); else passes++;
    cyc();
    checks++;
    if (o_itr[2] !== 1'b1 || o_addr[2] !== 9'd3)
      $display("FAIL lvl_rereq itr=%b addr=%0d want 1/3", o_itr[2], o_addr[2]);
    else passes++;
    src = 4'b0;
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      src = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      mask_wr = ($urandom_range(0, 15) == 0);
      mask_in = 4'($urandom_range(0, 15));
      itr_ack = ($urandom_range(0, 2) == 0);
      itr_ret = ($urandom_range(0, 5) == 0);
      cyc();
      for (int v = 0; v < 3; v++) begin
        checks++;
        if (o_itr[v] !== m_req[v] || o_pend[v] !== m_pend[v] || o_isv[v] !== m_isv[v] ||
            o_mask[v] !== m_mask)
          $display("FAIL rand c%0d v%0d itr=%b pend=%b isv=%b mask=%b want %b/%b/%b/%b", c, v,
                   o_itr[v], o_pend[v], o_isv[v], o_mask[v], m_req[v], m_pend[v], m_isv[v], m_mask);
        else passes++;
        if (m_req[v]) begin
          checks++;
          if (o_addr[v] !== 9'(1 + 2 * m_idx[v]))
            $display("FAIL rand_addr c%0d v%0d addr=%0d want %0d", c, v, o_addr[v], 1 + 2 * m_idx[v]);
          else passes++;
        end
      end
    end
    {rst, src, mask_wr, itr_ack, itr_ret} = '0;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_nest();
    test_boundary();
    test_level();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
